// File: rtl/program_rom_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program ROM loader.
// A byte moves only in a cycle where iByteValid and oByteReady are both high; oWriteEnable is a one-cycle strobe.
interface program_rom_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            iByte;
    logic                  iByteValid;
    logic                  oByteReady;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [27:0]           oWriteData;

    modport master (
        output iByte,
        output iByteValid,
        input  oByteReady,
        input  oWriteEnable,
        input  oWriteAddress,
        input  oWriteData
    );

    modport slave (
        input  iByte,
        input  iByteValid,
        output oByteReady,
        output oWriteEnable,
        output oWriteAddress,
        output oWriteData
    );
endinterface

// File: rtl/program_rom_loader.sv
// Fills the MiniAlu instruction RAM from a length-prefixed byte stream with a trailing XOR checksum,
// holding the core in reset until a load finishes cleanly.
module program_rom_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iStart,
    program_rom_loader_if.slave        bus,
    output logic                       oCpuReset,
    output logic                       oDone,
    output logic                       oError,
    output logic [2:0]                 oDebugState
);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [27:0]           data_q;
    logic                  cpu_reset_q;
    logic                  done_q;
    logic                  error_q;
    logic [7:0]            len_lo_q;
    logic [15:0]           len_q;
    logic [15:0]           word_cnt_q;
    logic [1:0]            byte_cnt_q;
    logic [7:0]            chk_q;
    logic [23:0]           asm_q;

    logic        accept;
    logic [15:0] n_word;
    logic        last_byte;
    logic        last_word;
    logic        clear;

    assign accept    = bus.iByteValid & ready_q;
    assign n_word    = {bus.iByte, len_lo_q};
    assign last_byte = (byte_cnt_q == 2'd3);
    assign last_word = (word_cnt_q == (len_q - 16'd1));
    assign clear     = iStart && (state_q == IDLE || state_q == DONE || state_q == ERROR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (iStart) state_d = LEN_LO;
            LEN_LO: if (accept) state_d = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if ({1'b0, n_word} > DEPTH) state_d = ERROR;
                    else if (n_word == 16'd0)   state_d = CHK;
                    else                        state_d = DATA;
                end
            end
            DATA:   if (accept && last_byte && last_word) state_d = CHK;
            CHK:    if (accept) state_d = (bus.iByte == chk_q) ? DONE : ERROR;
            DONE,
            ERROR:  if (iStart) state_d = LEN_LO;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track the FSM one edge later.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            chk_q       <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d inside {LEN_LO, LEN_HI, DATA, CHK});
            cpu_reset_q <= (state_d != DONE);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERROR);
            we_q        <= 1'b0;

            if (clear) begin
                len_lo_q   <= '0;
                len_q      <= '0;
                word_cnt_q <= '0;
                byte_cnt_q <= '0;
                chk_q      <= '0;
                asm_q      <= '0;
            end

            if (accept) begin
                case (state_q)
                    LEN_LO: len_lo_q <= bus.iByte;
                    LEN_HI: len_q    <= n_word;
                    DATA: begin
                        chk_q      <= chk_q ^ bus.iByte;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: asm_q[7:0]   <= bus.iByte;
                            2'd1: asm_q[15:8]  <= bus.iByte;
                            2'd2: asm_q[23:16] <= bus.iByte;
                            default: begin
                                // Upper nibble of the 4th byte is dropped from the word, not from the checksum.
                                we_q       <= 1'b1;
                                addr_q     <= word_cnt_q[ADDR_WIDTH-1:0];
                                data_q     <= {bus.iByte[3:0], asm_q};
                                word_cnt_q <= word_cnt_q + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.oByteReady    = ready_q;
    assign bus.oWriteEnable  = we_q;
    assign bus.oWriteAddress = addr_q;
    assign bus.oWriteData    = data_q;
    assign oCpuReset         = cpu_reset_q;
    assign oDone             = done_q;
    assign oError            = error_q;
    assign oDebugState       = state_q;
endmodule

// File: tb/tb_program_rom_loader.sv
// Directed bench for program_rom_loader: write strobes are scoreboarded against a queue of expected {addr, data}.
module tb_program_rom_loader;
    localparam int AW = 8;
    localparam int EW = AW + 28;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iStart = 1'b0;
    logic       oCpuReset;
    logic       oDone;
    logic       oError;
    logic [2:0] oDebugState;

    program_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_rom_loader #(.ADDR_WIDTH(AW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iStart      (iStart),
        .bus         (bus),
        .oCpuReset   (oCpuReset),
        .oDone       (oDone),
        .oError      (oError),
        .oDebugState (oDebugState)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int rd_idx = 0;
    logic [7:0] run_chk;

    // Monitor: every cycle with a strobe is one observed write.
    always @(negedge Clock) begin
        if (bus.oWriteEnable === 1'b1)
            got_q.push_back({bus.oWriteAddress, bus.oWriteData});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int n;
        g = $urandom_range(gap_max, 0);
        repeat (g) tick();
        bus.iByte      = b;
        bus.iByteValid = 1'b1;
        n = 0;
        while (bus.oByteReady !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(bus.oByteReady), 64'd1);
        tick();
        bus.iByteValid = 1'b0;
    endtask

    task automatic send_word(input int addr, input logic [31:0] w, input int gap_max);
        logic [AW-1:0] a;
        logic [7:0] b0, b1, b2, b3;
        a  = addr[AW-1:0];
        b0 = w[7:0];
        b1 = w[15:8];
        b2 = w[23:16];
        b3 = w[31:24];
        exp_q.push_back({a, b3[3:0], b2, b1, b0});
        run_chk = run_chk ^ b0 ^ b1 ^ b2 ^ b3;
        send_byte(b0, gap_max);
        send_byte(b1, gap_max);
        send_byte(b2, gap_max);
        send_byte(b3, gap_max);
    endtask

    task automatic run_scn1(input int gap_max, input logic [7:0] chk_byte);
        run_chk = 8'h00;
        pulse_start();
        send_byte(8'h02, gap_max);
        send_byte(8'h00, gap_max);
        send_word(0, 32'h04030201, gap_max);
        send_word(1, 32'h05302010, gap_max);
        send_byte(chk_byte, gap_max);
    endtask

    task automatic compare_writes(input string tag);
        logic [EW-1:0] e;
        logic [EW-1:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < got_q.size()) o = got_q[rd_idx];
            else o = 'x;
            rd_idx++;
            check({tag, "_write"}, 64'(o), 64'(e));
        end
        check({tag, "_strobe_count"}, 64'(got_q.size()), 64'(rd_idx));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  64'(oDebugState),       64'd0);
        check({tag, "_ready"},  64'(bus.oByteReady),    64'd0);
        check({tag, "_we"},     64'(bus.oWriteEnable),  64'd0);
        check({tag, "_addr"},   64'(bus.oWriteAddress), 64'd0);
        check({tag, "_data"},   64'(bus.oWriteData),    64'd0);
        check({tag, "_cpurst"}, 64'(oCpuReset),         64'd1);
        check({tag, "_done"},   64'(oDone),             64'd0);
        check({tag, "_error"},  64'(oError),            64'd0);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},   64'(oDone),          64'd1);
        check({tag, "_cpurst"}, 64'(oCpuReset),      64'd0);
        check({tag, "_error"},  64'(oError),         64'd0);
        check({tag, "_ready"},  64'(bus.oByteReady), 64'd0);
    endtask

    initial begin
        logic [EW-1:0] last;
        bus.iByte      = 8'h00;
        bus.iByteValid = 1'b0;

        // Reset values
        Reset = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        Reset = 1'b0;
        tick();
        check("idle_hold_state", 64'(oDebugState), 64'd0);

        // Scenario 1 with strobe timing checked directly
        run_chk = 8'h00;
        pulse_start();
        check("start_ready", 64'(bus.oByteReady), 64'd1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        check("len_cpurst", 64'(oCpuReset), 64'd1);
        send_word(0, 32'h04030201, 0);
        check("w0_we",   64'(bus.oWriteEnable),  64'd1);
        check("w0_addr", 64'(bus.oWriteAddress), 64'd0);
        check("w0_data", 64'(bus.oWriteData),    64'h4030201);
        send_word(1, 32'h05302010, 0);
        check("w1_we",   64'(bus.oWriteEnable),  64'd1);
        check("w1_addr", 64'(bus.oWriteAddress), 64'd1);
        check("w1_data", 64'(bus.oWriteData),    64'h5302010);
        check("scn1_chk_model", 64'(run_chk), 64'h01);
        send_byte(8'h01, 0);
        check_done("scn1");
        tick();
        compare_writes("scn1");

        // Bad checksum, then recovery
        run_scn1(0, 8'h00);
        check("badchk_error",  64'(oError),         64'd1);
        check("badchk_cpurst", 64'(oCpuReset),      64'd1);
        check("badchk_done",   64'(oDone),          64'd0);
        check("badchk_ready",  64'(bus.oByteReady), 64'd0);
        tick();
        check("badchk_ready_hold", 64'(bus.oByteReady), 64'd0);
        check("badchk_state",      64'(oDebugState),    64'd6);
        compare_writes("badchk");
        run_scn1(0, 8'h01);
        check_done("recover");
        tick();
        compare_writes("recover");

        // Start together with a valid byte in IDLE, then an empty program
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        iStart         = 1'b1;
        bus.iByteValid = 1'b1;
        bus.iByte      = 8'h02;
        tick();
        iStart         = 1'b0;
        bus.iByteValid = 1'b0;
        check("idle_byte_state", 64'(oDebugState),    64'd1);
        check("idle_byte_ready", 64'(bus.oByteReady), 64'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_done("n0");
        tick();
        compare_writes("n0");

        // Restart from DONE, then an oversized length
        pulse_start();
        check("restart_cpurst", 64'(oCpuReset), 64'd1);
        check("restart_done",   64'(oDone),     64'd0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("n257_error",  64'(oError),      64'd1);
        check("n257_cpurst", 64'(oCpuReset),   64'd1);
        check("n257_state",  64'(oDebugState), 64'd6);
        tick();
        compare_writes("n257");

        // Full-depth program
        run_chk = 8'h00;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int k = 0; k < 256; k++) send_word(k, $urandom, 0);
        send_byte(run_chk, 0);
        check_done("n256");
        tick();
        last = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
        check("n256_last_addr", 64'(last[EW-1:28]), 64'hFF);
        compare_writes("n256");

        // Scenario 1 with random valid gaps
        run_scn1(3, 8'h01);
        check_done("gaps");
        tick();
        compare_writes("gaps");

        // Reset in the middle of a load
        run_chk = 8'h00;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(0, 32'h04030201, 0);
        send_byte(8'h10, 0);
        Reset = 1'b1;
        tick();
        check_reset_vals("midreset");
        Reset = 1'b0;
        tick();
        check("midreset_state", 64'(oDebugState), 64'd0);
        compare_writes("midreset");
        run_scn1(0, 8'h01);
        check_done("rerun");
        tick();
        compare_writes("rerun");
        pulse_start();
        check("final_cpurst", 64'(oCpuReset),      64'd1);
        check("final_done",   64'(oDone),          64'd0);
        check("final_ready",  64'(bus.oByteReady), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_rom_loader.md
Name: program_rom_loader

Overview:
- Writer side of the MiniAlu instruction store. The core reads 28-bit instructions by IP; this block fills an instruction RAM that takes that role.
- Accepts a byte stream over a valid/ready handshake. Assembles 28-bit instruction words, writes them sequentially from address 0, and checks a trailing XOR checksum.
- Holds the core in reset until a load completes cleanly. Sits between a host byte source (UART RX or bench) and the instruction RAM write port.

Parameters:
- ADDR_WIDTH, 8, instruction RAM address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- Clock  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle pulse that begins a load
- iByte  in  8  stream data byte
- iByteValid  in  1  iByte is valid this cycle
- oByteReady  out  1  loader accepts a byte this cycle
- oWriteEnable  out  1  one-cycle instruction RAM write strobe
- oWriteAddress  out  ADDR_WIDTH  instruction RAM write address
- oWriteData  out  28  instruction word
- oCpuReset  out  1  reset to the core; high unless a load has completed
- oDone  out  1  load completed with a good checksum
- oError  out  1  load aborted (bad length or bad checksum)

Behaviour:
- Reset values: state IDLE, oByteReady 0, oWriteEnable 0, oWriteAddress 0, oWriteData 0, oCpuReset 1, oDone 0, oError 0. Word and byte counters and the checksum accumulator are 0.
- Handshake: a byte is accepted only in a cycle where iByteValid & oByteReady are both 1. oByteReady is a registered function of state: 1 in LEN_LO, LEN_HI, DATA and CHK; 0 elsewhere. Gaps in iByteValid stall the loader with no side effects.
- Stream format: N_lo, N_hi (16-bit word count N, little-endian), then N×4 data bytes, then one checksum byte.
- Checksum: XOR of all data bytes only; the length bytes are excluded.
- Word assembly: bytes b0, b1, b2, b3 form oWriteData = {b3[3:0], b2, b1, b0}. b3[7:4] is ignored but still included in the checksum.
- State machine:
  - IDLE: iStart → LEN_LO; clear counters and accumulator.
  - LEN_LO: on accept, latch N_lo → LEN_HI.
  - LEN_HI: on accept, form N.
    - N > DEPTH → ERROR.
    - N == 0 → CHK.
    - Otherwise → DATA.
  - DATA: on each accept, XOR the byte into the accumulator and advance the byte counter. After the 4th byte of word k, oWriteEnable pulses for exactly one cycle, the cycle after that accept, with oWriteAddress = k and the assembled data. After word N-1's 4th byte → CHK.
  - CHK: on accept, byte == accumulator → DONE, else → ERROR.
  - DONE: oDone 1, oCpuReset 0.
  - ERROR: oError 1, oCpuReset 1.
  - From DONE or ERROR, iStart → LEN_LO. oCpuReset goes back to 1, oDone and oError clear, counters clear.
- oCpuReset, oDone and oError change the cycle after the transition condition, because they are registered.
- The last word's write strobe always precedes oDone by at least one cycle.
- iStart while in LEN_LO, LEN_HI, DATA or CHK is ignored.
- iStart and iByteValid together in IDLE: the byte is not accepted, because oByteReady is 0 that cycle.
- Address never wraps: N ≤ DEPTH is guaranteed by the length check. N == DEPTH is legal and writes addresses 0..DEPTH-1.
- Reset during any state: return to IDLE with reset values on the next edge. Any pending write strobe is dropped.

Test Plan:
- Reset, iStart, stream 02 00 | 01 02 03 04 | 10 20 30 05 | 01 → writes addr0=0x4030201 and addr1=0x5302010, one strobe each. oDone=1 and oCpuReset=0 the cycle after the checksum accept.
- Same stream with checksum 00 → no DONE; oError=1, oCpuReset stays 1, oByteReady=0 afterwards. Then iStart plus the good stream → DONE.
- N=0: stream 00 00 00 → DONE, zero write strobes.
- ADDR_WIDTH=8, stream 01 01 (N=257) → ERROR right after the 2nd byte, no writes. Stream 00 01 (N=256) plus 1024 bytes plus correct checksum → DONE, last write at addr 0xFF.
- Scenario 1 with iByteValid randomly deasserted 0–3 cycles between bytes → identical writes and result, no extra strobes.
- Reset asserted after the 5th data byte of scenario 1 → all outputs at reset values the next cycle. Rerun scenario 1 → DONE. Then iStart in DONE → oCpuReset=1 and oDone=0 the next cycle.
